// File: rtl/abacus_pkg.sv
// rtl/abacus_pkg.sv - shared encodings and defaults for the Abacus operation sequencer
package abacus_pkg;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_MUL_LAT         = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_QUO = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_MUL_WAIT,
        S_DIV_WAIT,
        S_HOLD
    } state_e;
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, stable-level debouncer and press pulse
module btn_debounce
    import abacus_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            // A level is accepted only after CYCLES consecutive samples disagree with the current one.
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                stable <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end
endmodule

// File: rtl/abacus_op_ctrl.sv
// rtl/abacus_op_ctrl.sv - Abacus operation sequencer: debounced ops, operand snapshot, result register
module abacus_op_ctrl
    import abacus_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MUL_LAT         = DEF_MUL_LAT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_r,
    input  logic        btn_l,
    input  logic [7:0]  sw_a,
    input  logic [7:0]  sw_b,
    output logic [7:0]  a_lat,
    output logic [7:0]  b_lat,
    input  logic [8:0]  sum_in,
    input  logic [15:0] product_in,
    output logic        div_start,
    input  logic        div_done,
    input  logic [7:0]  quo_in,
    input  logic [7:0]  rem_in,
    output logic [2:0]  op,
    output logic [15:0] result,
    output logic        neg,
    output logic        div_by_zero,
    output logic        busy,
    output logic        scroll_clr
);
    localparam int MCW = $clog2(MUL_LAT + 1);

    logic [3:0]     raw_btn;
    logic [3:0]     ev;
    logic           press;
    logic [2:0]     press_op;
    state_e         state;
    state_e         state_n;
    logic [MCW-1:0] mul_cnt;
    logic [MCW-1:0] cnt_d;
    logic           latch_go;
    logic           res_we;
    logic [15:0]    res_d;
    logic           neg_d;
    logic           dbz_d;
    logic           start_d;
    logic           scroll_d;
    logic           a_ge_b;
    logic [7:0]     sub_mag;

    assign raw_btn = {btn_l, btn_r, btn_d, btn_u};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .clr   (clr),
            .btn   (raw_btn[i]),
            .press (ev[i])
        );
    end

    // Simultaneous events resolve U > D > R > L; the losers are discarded.
    always_comb begin
        press    = 1'b1;
        press_op = OP_ADD;
        if (ev[0])      press_op = OP_SUB;
        else if (ev[1]) press_op = OP_MUL;
        else if (ev[2]) press_op = OP_QUO;
        else if (ev[3]) press_op = OP_REM;
        else            press    = 1'b0;
    end

    assign a_ge_b  = (a_lat >= b_lat);
    assign sub_mag = a_ge_b ? (a_lat - b_lat) : (b_lat - a_lat);
    assign busy    = (state == S_LATCH) || (state == S_MUL_WAIT) || (state == S_DIV_WAIT);

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        latch_go = 1'b0;
        res_we   = 1'b0;
        res_d    = result;
        neg_d    = neg;
        dbz_d    = div_by_zero;
        start_d  = 1'b0;
        scroll_d = 1'b0;
        cnt_d    = mul_cnt;
        case (state)
            S_IDLE: begin
                res_we   = 1'b1;
                res_d    = {7'b0, sum_in};
                scroll_d = ({7'b0, sum_in} != result);
                if (press) begin
                    state_n  = S_LATCH;
                    latch_go = 1'b1;
                end
            end
            S_LATCH: begin
                case (op)
                    OP_SUB: begin
                        state_n  = S_HOLD;
                        res_we   = 1'b1;
                        res_d    = {8'b0, sub_mag};
                        neg_d    = ~a_ge_b;
                        scroll_d = 1'b1;
                    end
                    OP_MUL: begin
                        state_n = S_MUL_WAIT;
                        cnt_d   = '0;
                    end
                    OP_QUO, OP_REM: begin
                        if (b_lat != 8'd0) begin
                            state_n = S_DIV_WAIT;
                            start_d = 1'b1;
                        end else begin
                            state_n  = S_HOLD;
                            res_we   = 1'b1;
                            res_d    = (op == OP_QUO) ? 16'h00FF : {8'b0, a_lat};
                            dbz_d    = 1'b1;
                            scroll_d = 1'b1;
                        end
                    end
                    default: state_n = S_HOLD;
                endcase
            end
            S_MUL_WAIT: begin
                if (mul_cnt == MCW'(MUL_LAT - 1)) begin
                    state_n  = S_HOLD;
                    res_we   = 1'b1;
                    res_d    = product_in;
                    scroll_d = 1'b1;
                end else begin
                    cnt_d = mul_cnt + MCW'(1);
                end
            end
            S_DIV_WAIT: begin
                if (div_done) begin
                    state_n  = S_HOLD;
                    res_we   = 1'b1;
                    res_d    = (op == OP_QUO) ? {8'b0, quo_in} : {8'b0, rem_in};
                    scroll_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (press) begin
                    state_n  = S_LATCH;
                    latch_go = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (latch_go) begin
            neg_d = 1'b0;
            dbz_d = 1'b0;
        end
    end

    // Operands follow the switches only in IDLE; afterwards they form a frozen snapshot.
    always_ff @(posedge clk) begin
        if (clr) begin
            a_lat       <= '0;
            b_lat       <= '0;
            op          <= OP_ADD;
            result      <= '0;
            neg         <= 1'b0;
            div_by_zero <= 1'b0;
            div_start   <= 1'b0;
            scroll_clr  <= 1'b0;
            mul_cnt     <= '0;
        end else begin
            if (state == S_IDLE || latch_go) begin
                a_lat <= sw_a;
                b_lat <= sw_b;
            end
            if (latch_go) op <= press_op;
            if (res_we) result <= res_d;
            neg         <= neg_d;
            div_by_zero <= dbz_d;
            div_start   <= start_d;
            scroll_clr  <= scroll_d;
            mul_cnt     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_abacus_op_ctrl.sv
// tb/tb_abacus_op_ctrl.sv - self-checking bench for abacus_op_ctrl
module tb_abacus_op_ctrl;
    localparam int DEB      = 4;
    localparam int MLAT     = 2;
    localparam int DIV_LAT  = 9;
    // edges from raising a button until LATCH is visible: event latency plus one
    localparam int EV_EDGES = 2 + DEB + 1 + 1;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  btns;
    logic [7:0]  sw_a, sw_b, a_lat, b_lat;
    logic [7:0]  quo_in = 8'd0;
    logic [7:0]  rem_in = 8'd0;
    logic [8:0]  sum_in;
    logic [15:0] p1 = 16'd0;
    logic [15:0] product_in = 16'd0;
    logic [15:0] result;
    logic        div_start;
    logic        div_done = 1'b0;
    logic [2:0]  op;
    logic        neg, div_by_zero, busy, scroll_clr;
    logic [7:0]  dq_a = 8'd0;
    logic [7:0]  dq_b = 8'd1;
    int          dcnt = 0;
    int          start_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        neg;
        logic        dbz;
    } vec_t;
    vec_t vecs[8];

    abacus_op_ctrl #(.DEBOUNCE_CYCLES(DEB), .MUL_LAT(MLAT)) dut (
        .clk         (clk),
        .clr         (clr),
        .btn_u       (btns[0]),
        .btn_d       (btns[1]),
        .btn_r       (btns[2]),
        .btn_l       (btns[3]),
        .sw_a        (sw_a),
        .sw_b        (sw_b),
        .a_lat       (a_lat),
        .b_lat       (b_lat),
        .sum_in      (sum_in),
        .product_in  (product_in),
        .div_start   (div_start),
        .div_done    (div_done),
        .quo_in      (quo_in),
        .rem_in      (rem_in),
        .op          (op),
        .result      (result),
        .neg         (neg),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .scroll_clr  (scroll_clr)
    );

    always #5 clk = ~clk;

    assign sum_in = {1'b0, a_lat} + {1'b0, b_lat};

    always @(posedge clk) begin
        p1         <= a_lat * b_lat;
        product_in <= p1;
    end

    // divider: completes DIV_LAT cycles after start, keeps running across clr
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                div_done <= 1'b1;
                quo_in   <= dq_a / dq_b;
                rem_in   <= dq_a % dq_b;
            end
        end
        if (div_start) begin
            dcnt      <= DIV_LAT - 1;
            dq_a      <= a_lat;
            dq_b      <= b_lat;
            start_cnt <= start_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic ref_model(input int idx, input int a, input int b,
                             output int r, output int ng, output int dz);
        ng = 0;
        dz = 0;
        case (idx)
            0: begin r = (a >= b) ? a - b : b - a; ng = (a < b) ? 1 : 0; end
            1: r = a * b;
            2: begin if (b == 0) begin r = 255; dz = 1; end else r = a / b; end
            default: begin if (b == 0) begin r = a; dz = 1; end else r = a % b; end
        endcase
    endtask

    function automatic int exp_lat(input int idx, input int b);
        if (idx == 0) return 1;
        if (idx == 1) return MLAT + 1;
        return (b == 0) ? 1 : DIV_LAT + 2;
    endfunction

    task automatic wait_latch(input string tag, output bit seen);
        int n;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = busy;
        end
        check({tag, "_press_to_latch"}, n, EV_EDGES);
    endtask

    task automatic do_op(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                         input int er, input int en, input int ed);
        bit seen;
        int lat, s0;
        sw_a      = a;
        sw_b      = b;
        btns[idx] = 1'b1;
        wait_latch(tag, seen);
        btns = '0;
        if (seen) begin
            s0 = start_cnt;
            check({tag, "_op"}, int'(op), idx + 1);
            check({tag, "_a_lat"}, int'(a_lat), int'(a));
            check({tag, "_neg_clear"}, int'(neg), 0);
            sw_a = 8'($urandom);
            sw_b = 8'($urandom);
            lat  = 0;
            while (busy && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check({tag, "_latency"}, lat, exp_lat(idx, int'(b)));
            check({tag, "_result"}, int'(result), er);
            check({tag, "_neg"}, int'(neg), en);
            check({tag, "_dbz"}, int'(div_by_zero), ed);
            check({tag, "_scroll"}, int'(scroll_clr), 1);
            check({tag, "_b_frozen"}, int'(b_lat), int'(b));
            check({tag, "_starts"}, start_cnt - s0, (idx >= 2 && b != 8'd0) ? 1 : 0);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int  cnt, idx, a, b, r, ng, dz, s0;
        bit  seen;

        vecs[0] = '{0, 8'd20,  8'd45,  16'd25,    1'b1, 1'b0};
        vecs[1] = '{0, 8'd7,   8'd7,   16'd0,     1'b0, 1'b0};
        vecs[2] = '{1, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0};
        vecs[3] = '{2, 8'd200, 8'd7,   16'd28,    1'b0, 1'b0};
        vecs[4] = '{3, 8'd200, 8'd7,   16'd4,     1'b0, 1'b0};
        vecs[5] = '{2, 8'd13,  8'd0,   16'h00FF,  1'b0, 1'b1};
        vecs[6] = '{3, 8'd9,   8'd0,   16'd9,     1'b0, 1'b1};
        vecs[7] = '{0, 8'd50,  8'd8,   16'd42,    1'b0, 1'b0};

        clr  = 1'b1;
        btns = '0;
        sw_a = 8'h5A;
        sw_b = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op", int'(op), 0);
        check("rst_a_lat", int'(a_lat), 0);
        check("rst_b_lat", int'(b_lat), 0);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'({neg, div_by_zero, busy, div_start, scroll_clr}), 0);

        sw_a = 8'd3;
        sw_b = 8'd4;
        clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_sum", int'(result), 7);
        check("idle_scroll", int'(scroll_clr), 1);
        check("idle_op", int'(op), 0);
        @(posedge clk); #1;
        check("idle_scroll_once", int'(scroll_clr), 0);
        sw_a = 8'd200;
        sw_b = 8'd100;
        repeat (2) @(posedge clk);
        #1;
        check("idle_carry", int'(result), 300);
        check("idle_carry_scroll", int'(scroll_clr), 1);

        btns[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btns[0] = 1'b0;
        cnt = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (busy) cnt++;
        end
        check("glitch_busy", cnt, 0);
        check("glitch_op", int'(op), 0);

        btns[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (i == 7) btns[0] = 1'b0;
            if (busy) cnt++;
        end
        check("held_events", cnt, 1);
        check("held_op", int'(op), 1);
        check("held_result", int'(result), 100);

        for (int i = 0; i < 8; i++)
            do_op($sformatf("tbl%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b,
                  int'(vecs[i].res), int'(vecs[i].neg), int'(vecs[i].dbz));

        // a MUL press landing in DIV_WAIT must be discarded
        sw_a    = 8'd200;
        sw_b    = 8'd7;
        s0      = start_cnt;
        btns[2] = 1'b1;
        wait_latch("drop", seen);
        btns = 4'b0010;
        repeat (12) @(posedge clk);
        #1;
        btns = '0;
        cnt  = 0;
        while (busy && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("drop_result", int'(result), 28);
        check("drop_op", int'(op), 3);
        check("drop_starts", start_cnt - s0, 1);
        cnt = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (busy) cnt++;
        end
        check("drop_no_rerun", cnt, 0);
        check("drop_op_kept", int'(op), 3);

        // clr while the divider is running, then a late div_done
        btns[2] = 1'b1;
        wait_latch("clr", seen);
        btns = '0;
        repeat (3) @(posedge clk);
        #1;
        check("clr_in_div_wait", int'(busy), 1);
        clr = 1'b1;
        @(posedge clk); #1;
        check("clr_op", int'(op), 0);
        check("clr_a_lat", int'(a_lat), 0);
        check("clr_b_lat", int'(b_lat), 0);
        check("clr_result", int'(result), 0);
        check("clr_flags", int'({neg, div_by_zero, busy, div_start, scroll_clr}), 0);
        clr  = 1'b0;
        sw_a = 8'd1;
        sw_b = 8'd2;
        s0   = start_cnt;
        cnt  = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (busy) cnt++;
        end
        check("clr_no_start", start_cnt - s0, 0);
        check("clr_late_busy", cnt, 0);
        check("clr_late_result", int'(result), 3);
        check("clr_late_op", int'(op), 0);

        for (int i = 0; i < 12; i++) begin
            idx = int'($urandom_range(0, 3));
            a   = int'($urandom_range(0, 255));
            b   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
            ref_model(idx, a, b, r, ng, dz);
            do_op($sformatf("rnd%0d", i), idx, 8'(a), 8'(b), r, ng, dz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
